// File: rtl/cdb_aging_arbiter_pkg.sv
// cdb_aging_arbiter_pkg: shared configuration constants and helpers for the CDB aging arbiter
package cdb_aging_arbiter_pkg;
  localparam int MAX_EU_N       = 5;
  localparam int CDB_STARVE_MAX = 4;
  function automatic int starve_w(input int smax);
    return smax > 0 ? $clog2(smax + 1) : 1;
  endfunction
endpackage

// File: rtl/cdb_aging_arbiter_if.sv
// cdb_aging_arbiter_if: EU/RS/ROB handshake bundle; master drives requests, slave is the arbiter
interface cdb_aging_arbiter_if #(
  parameter int N_RS = 4,
  localparam int IDX_W = $clog2(N_RS)
);
  logic             flush_i;
  logic             max_prio_valid_i;
  logic             max_prio_ready_o;
  logic [N_RS-1:0]  valid_i;
  logic [N_RS-1:0]  ready_o;
  logic             rob_ready_i;
  logic             rob_valid_o;
  logic             served_max_prio_o;
  logic [IDX_W-1:0] served_o;
  modport master (
    output flush_i, max_prio_valid_i, valid_i, rob_ready_i,
    input  max_prio_ready_o, ready_o, rob_valid_o, served_max_prio_o, served_o
  );
  modport slave (
    input  flush_i, max_prio_valid_i, valid_i, rob_ready_i,
    output max_prio_ready_o, ready_o, rob_valid_o, served_max_prio_o, served_o
  );
endinterface

// File: rtl/cdb_aging_arbiter_rr_picker.sv
// cdb_rr_picker: first valid index searching cyclically from ptr_i (rotate, priority-encode, un-rotate)
module cdb_rr_picker #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;
  always_comb begin
    rot = '0;
    for (int j = 0; j < N; j++) rot[j] = valid_i[(int'(ptr_i) + j) % N];
    off = '0;
    for (int j = N - 1; j >= 0; j--) if (rot[j]) off = IW'(j);
    sum = {1'b0, ptr_i} + {1'b0, off};
    idx_o = sum >= (IW + 1)'(N) ? IW'(sum - (IW + 1)'(N)) : sum[IW-1:0];
  end
  assign any_o = |valid_i;
endmodule

// File: rtl/cdb_aging_arbiter.sv
// cdb_aging_arbiter: CDB arbiter, max-priority EU vs round-robin RSs with aging against starvation
module cdb_aging_arbiter
  import cdb_aging_arbiter_pkg::*;
#(
  parameter int N_RS       = MAX_EU_N - 1,
  parameter int STARVE_MAX = CDB_STARVE_MAX,
  localparam int IDX_W = $clog2(N_RS),
  localparam int SW    = starve_w(STARVE_MAX)
) (
  input logic clk_i,
  input logic rst_i,
  cdb_aging_arbiter_if.slave bus
);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  logic [IDX_W-1:0] ptr_q, ptr_d, cand;
  logic [SW-1:0]    starve_q, starve_d;
  logic             any_lp, boost, grant_mp, hs_en, lp_xfer, mp_xfer;
  cdb_rr_picker #(.N(N_RS)) u_pick (
    .valid_i(bus.valid_i),
    .ptr_i  (ptr_q),
    .idx_o  (cand),
    .any_o  (any_lp)
  );
  assign boost    = (STARVE_MAX != 0) && starve_q == SMAX && any_lp;
  assign grant_mp = bus.max_prio_valid_i && !boost;
  // reset forces every output low; flush only silences the handshake
  assign hs_en                 = !rst_i && !bus.flush_i;
  assign bus.rob_valid_o       = hs_en && (bus.max_prio_valid_i || any_lp);
  assign bus.served_max_prio_o = !rst_i && grant_mp;
  assign bus.served_o          = rst_i ? '0 : cand;
  assign bus.max_prio_ready_o  = hs_en && grant_mp && bus.rob_ready_i;
  assign bus.ready_o           = (hs_en && !grant_mp && any_lp && bus.rob_ready_i) ? N_RS'(1) << cand : '0;
  assign lp_xfer = |(bus.valid_i & bus.ready_o);
  assign mp_xfer = bus.max_prio_valid_i && bus.max_prio_ready_o;
  always_comb begin
    ptr_d    = bus.flush_i ? '0 : lp_xfer ? (cand == IDX_W'(N_RS - 1) ? '0 : cand + 1'b1) : ptr_q;
    starve_d = (bus.flush_i || lp_xfer || !any_lp) ? '0 :
               (mp_xfer && starve_q != SMAX) ? starve_q + 1'b1 : starve_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q    <= '0;
      starve_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      starve_q <= starve_d;
    end
  end
endmodule

// File: tb/tb_cdb_aging_arbiter.sv
module tb_cdb_aging_arbiter;
  localparam int N  = 4;
  localparam int SM = 3;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  int m_ptr = 0;
  int m_starve = 0;
  int e_srv, e_rdy, e_mpr, e_robv, e_smp;
  cdb_aging_arbiter_if #(.N_RS(N)) bus ();
  cdb_aging_arbiter #(.N_RS(N), .STARVE_MAX(SM)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic       mpv;
    logic [3:0] v;
    logic       rr;
    logic       fl;
    int         srv;
    int         smp;
    int         rdy;
    int         mpr;
    int         robv;
  } vec_t;
  vec_t tbl[16];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic mpv, input logic [3:0] v, input logic rr, input logic fl);
    bus.max_prio_valid_i = mpv;
    bus.valid_i = v;
    bus.rob_ready_i = rr;
    bus.flush_i = fl;
  endtask
  // reference: scan requesters from the round-robin start, apply the aging rule
  task automatic model_eval();
    int c;
    bit any, gmp;
    any = bus.valid_i != 0;
    c = m_ptr;
    for (int k = N - 1; k >= 0; k--) if (bus.valid_i[(m_ptr + k) % N]) c = (m_ptr + k) % N;
    gmp = bus.max_prio_valid_i && !(m_starve == SM && any);
    e_srv  = c;
    e_smp  = int'(gmp);
    e_robv = int'(!bus.flush_i && (bus.max_prio_valid_i || any));
    e_mpr  = int'(!bus.flush_i && gmp && bus.rob_ready_i);
    e_rdy  = (!bus.flush_i && !gmp && any && bus.rob_ready_i) ? (1 << c) : 0;
  endtask
  task automatic model_update();
    if (bus.flush_i) begin
      m_ptr = 0;
      m_starve = 0;
    end else if (e_rdy != 0) begin
      m_ptr = (e_srv + 1) % N;
      m_starve = 0;
    end else if (bus.valid_i == 0) m_starve = 0;
    else if (e_mpr != 0 && m_starve < SM) m_starve++;
  endtask
  task automatic model_check(input string tag);
    model_eval();
    chk({tag, ".served"}, int'(bus.served_o), e_srv);
    chk({tag, ".smp"}, int'(bus.served_max_prio_o), e_smp);
    chk({tag, ".robv"}, int'(bus.rob_valid_o), e_robv);
    chk({tag, ".mpr"}, int'(bus.max_prio_ready_o), e_mpr);
    chk({tag, ".rdy"}, int'(bus.ready_o), e_rdy);
  endtask
  // one cycle: inputs settle, outputs checked, then the clock edge commits state
  task automatic step(input string tag);
    #2;
    model_check(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask
  initial begin
    tbl[0]  = '{0, 4'b1111, 1, 0, 0, 0, 1, 0, 1};
    tbl[1]  = '{0, 4'b1111, 1, 0, 1, 0, 2, 0, 1};
    tbl[2]  = '{0, 4'b1111, 1, 0, 2, 0, 4, 0, 1};
    tbl[3]  = '{0, 4'b1111, 1, 0, 3, 0, 8, 0, 1};
    tbl[4]  = '{0, 4'b1111, 1, 0, 0, 0, 1, 0, 1};
    tbl[5]  = '{0, 4'b0110, 1, 0, 1, 0, 2, 0, 1};
    tbl[6]  = '{0, 4'b0001, 1, 0, 0, 0, 1, 0, 1};
    tbl[7]  = '{0, 4'b0000, 1, 0, 1, 0, 0, 0, 0};
    tbl[8]  = '{1, 4'b0100, 1, 0, 2, 1, 0, 1, 1};
    tbl[9]  = '{1, 4'b0100, 1, 0, 2, 1, 0, 1, 1};
    tbl[10] = '{1, 4'b0100, 1, 0, 2, 1, 0, 1, 1};
    tbl[11] = '{1, 4'b0100, 1, 0, 2, 0, 4, 0, 1};
    tbl[12] = '{1, 4'b0100, 1, 0, 2, 1, 0, 1, 1};
    tbl[13] = '{1, 4'b0100, 0, 0, 2, 1, 0, 0, 1};
    tbl[14] = '{1, 4'b0100, 1, 1, 2, 1, 0, 0, 0};
    tbl[15] = '{0, 4'b1000, 1, 0, 3, 0, 8, 0, 1};
    drive(1, 4'b1111, 1, 0);
    #3;
    chk("rst.robv", int'(bus.rob_valid_o), 0);
    chk("rst.mpr", int'(bus.max_prio_ready_o), 0);
    chk("rst.rdy", int'(bus.ready_o), 0);
    chk("rst.smp", int'(bus.served_max_prio_o), 0);
    chk("rst.served", int'(bus.served_o), 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst.ptr", int'(dut.ptr_q), 0);
    chk("rst.first_mp", int'(bus.served_max_prio_o), 1);
    drive(0, 4'b0000, 1, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].mpv, tbl[i].v, tbl[i].rr, tbl[i].fl);
      #2;
      chk($sformatf("tbl%0d.served", i), int'(bus.served_o), tbl[i].srv);
      chk($sformatf("tbl%0d.smp", i), int'(bus.served_max_prio_o), tbl[i].smp);
      chk($sformatf("tbl%0d.rdy", i), int'(bus.ready_o), tbl[i].rdy);
      chk($sformatf("tbl%0d.mpr", i), int'(bus.max_prio_ready_o), tbl[i].mpr);
      chk($sformatf("tbl%0d.robv", i), int'(bus.rob_valid_o), tbl[i].robv);
      model_check($sformatf("tblm%0d", i));
      @(posedge clk);
      model_update();
      #1;
    end
    chk("flush.ptr", int'(dut.ptr_q), 0);
    chk("flush.starve", int'(dut.starve_q), 0);
    drive(1, 4'b0010, 1, 0);
    step("bp.pre0");
    step("bp.pre1");
    chk("bp.starve_pre", int'(dut.starve_q), 2);
    for (int i = 0; i < 4; i++) begin
      drive(1, 4'b0010, 0, 0);
      step($sformatf("bp%0d", i));
      chk("bp.ptr", int'(dut.ptr_q), m_ptr);
      chk("bp.starve", int'(dut.starve_q), 2);
    end
    drive(0, 4'b0100, 1, 0);
    step("fl.pre0");
    drive(1, 4'b0001, 1, 0);
    step("fl.pre1");
    step("fl.pre2");
    chk("fl.starve_pre", int'(dut.starve_q), 2);
    chk("fl.ptr_pre", int'(dut.ptr_q), 3);
    drive(1, 4'b0001, 1, 1);
    step("fl");
    chk("fl.ptr", int'(dut.ptr_q), 0);
    chk("fl.starve", int'(dut.starve_q), 0);
    drive(1, 4'b1000, 1, 0);
    step("drop.0");
    step("drop.1");
    step("drop.2");
    drive(1, 4'b0000, 0, 0);
    step("drop.3");
    chk("drop.starve", int'(dut.starve_q), 0);
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 19) == 0));
      step("rnd");
      if (i == 200) begin
        drive(1, 4'b1111, 1, 0);
        #1;
        rst = 1;
        #1;
        chk("midrst.robv", int'(bus.rob_valid_o), 0);
        chk("midrst.rdy", int'(bus.ready_o), 0);
        @(negedge clk);
        rst = 0;
        m_ptr = 0;
        m_starve = 0;
        #1;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
